// File: rtl/ff_pkg.sv
// Shared mode encoding for the configurable bistable register bank.
package ff_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK = 2'b00;
    localparam mode_t MODE_SR = 2'b01;
    localparam mode_t MODE_D  = 2'b10;
    localparam mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/jk_register_bank_if.sv
// Control/status bundle between a driver and the register bank.
interface jk_register_bank_if
    import ff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] sr_err;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output en, mode, j, k, load, load_data, clr_err,
        input  q, qn, sr_err, chg_cnt
    );

    modport slave (
        input  en, mode, j, k, load, load_data, clr_err,
        output q, qn, sr_err, chg_cnt
    );
endinterface

// File: rtl/jk_cell.sv
// Single-channel next-state logic for JK/SR/D/T behaviour plus SR-illegal detect.
module jk_cell
    import ff_pkg::*;
(
    input  mode_t mode,
    input  logic  j,
    input  logic  k,
    input  logic  q,
    output logic  q_next,
    output logic  err_set
);

    always_comb begin
        q_next  = q;
        err_set = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_SR: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   err_set = 1'b1;  // illegal: hold and flag
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = j;
            MODE_T:  q_next = j ? ~q : q;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH mode-selectable flip-flops with load, enable, sticky SR-error
// flags and a saturating count of bit transitions.
module jk_register_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    jk_register_bank_if.slave bus
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] qn_reg;
    logic [WIDTH-1:0] err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] cell_next, cell_err;
    logic [WIDTH-1:0] diff;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .mode    (bus.mode),
                .j       (bus.j[gi]),
                .k       (bus.k[gi]),
                .q       (q_reg[gi]),
                .q_next  (cell_next[gi]),
                .err_set (cell_err[gi])
            );
        end
    endgenerate

    always_comb begin
        q_next   = q_reg;
        err_next = err_reg;
        if (bus.load) begin
            q_next = bus.load_data;
        end else if (bus.en) begin
            q_next = cell_next;
        end
        if (bus.clr_err) begin
            err_next = '0;
        end
        // A fresh error is ORed in after the clear so it wins on a collision.
        if (bus.en && !bus.load) begin
            err_next = err_next | cell_err;
        end
    end

    always_comb begin
        diff = q_next ^ q_reg;
        pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
        sum      = SUM_W'(cnt_reg) + SUM_W'(pop);
        cnt_next = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= RST_VAL;
            qn_reg  <= ~RST_VAL;
            err_reg <= '0;
            cnt_reg <= '0;
        end else begin
            q_reg   <= q_next;
            qn_reg  <= ~q_next;
            err_reg <= err_next;
            cnt_reg <= cnt_next;
        end
    end

    assign bus.q       = q_reg;
    assign bus.qn      = qn_reg;
    assign bus.sr_err  = err_reg;
    assign bus.chg_cnt = cnt_reg;

endmodule

// File: tb/tb_jk_register_bank.sv
// Table-driven check of the register bank with a scoreboard queue of expected results.
module tb_jk_register_bank;
    import ff_pkg::*;

    localparam int W  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jk_register_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    jk_register_bank #(.WIDTH(W), .RST_VAL(4'b0000), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         rst;
        logic         en;
        mode_t        mode;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         load;
        logic [W-1:0] ld;
        logic         clr;
        logic [W-1:0] eq;
        logic [W-1:0] eerr;
        logic [CW-1:0] ecnt;
    } vec_t;

    typedef struct {
        int            idx;
        logic [W-1:0]  q;
        logic [W-1:0]  err;
        logic [CW-1:0] cnt;
    } exp_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    exp_t sb [$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst           = v.rst;
        bus.en        = v.en;
        bus.mode      = v.mode;
        bus.j         = v.j;
        bus.k         = v.k;
        bus.load      = v.load;
        bus.load_data = v.ld;
        bus.clr_err   = v.clr;
        e.idx = idx; e.q = v.eq; e.err = v.eerr; e.cnt = v.ecnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.q !== e.q) begin
            n_fail++;
            $display("FAIL q[%0d]: got %b want %b", e.idx, bus.q, e.q);
        end
        if (bus.qn !== ~e.q) begin
            n_fail++;
            $display("FAIL qn[%0d]: got %b want %b", e.idx, bus.qn, ~e.q);
        end
        if (bus.sr_err !== e.err) begin
            n_fail++;
            $display("FAIL sr_err[%0d]: got %b want %b", e.idx, bus.sr_err, e.err);
        end
        if (bus.chg_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL chg_cnt[%0d]: got %0d want %0d", e.idx, bus.chg_cnt, e.cnt);
        end
        $display("vec %0d: q=%b qn=%b sr_err=%b chg_cnt=%0d", e.idx, bus.q, bus.qn, bus.sr_err, bus.chg_cnt);
    endtask

    initial begin
        vec_t v;
        int   cnt_model;
        logic [W-1:0] q_model;

        rst = 1'b0; bus.en = 1'b0; bus.mode = MODE_JK; bus.j = '0; bus.k = '0;
        bus.load = 1'b0; bus.load_data = '0; bus.clr_err = 1'b0;

        //          rst  en   mode     j        k        load ld       clr  q        err      cnt
        vecs[0]  = '{1'b1,1'b0,MODE_JK,4'b0000,4'b0000,1'b0,4'b0000,1'b0,4'b0000,4'b0000,4'd0};
        vecs[1]  = '{1'b0,1'b1,MODE_JK,4'b1010,4'b0101,1'b0,4'b0000,1'b0,4'b1010,4'b0000,4'd2};
        vecs[2]  = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b0101,4'b0000,4'd6};
        vecs[3]  = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b1010,4'b0000,4'd10};
        vecs[4]  = '{1'b0,1'b1,MODE_SR,4'b0011,4'b0110,1'b0,4'b0000,1'b0,4'b1011,4'b0010,4'd11};
        vecs[5]  = '{1'b0,1'b1,MODE_SR,4'b0000,4'b0000,1'b0,4'b0000,1'b1,4'b1011,4'b0000,4'd11};
        vecs[6]  = '{1'b0,1'b1,MODE_SR,4'b0010,4'b0010,1'b0,4'b0000,1'b0,4'b1011,4'b0010,4'd11};
        vecs[7]  = '{1'b0,1'b1,MODE_SR,4'b0010,4'b0010,1'b0,4'b0000,1'b1,4'b1011,4'b0010,4'd11};
        vecs[8]  = '{1'b0,1'b1,MODE_T, 4'b1111,4'b0000,1'b1,4'b1100,1'b0,4'b1100,4'b0010,4'd14};
        vecs[9]  = '{1'b0,1'b0,MODE_T, 4'b1111,4'b0000,1'b0,4'b0000,1'b0,4'b1100,4'b0010,4'd14};
        vecs[10] = '{1'b0,1'b0,MODE_SR,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b1100,4'b0010,4'd14};
        vecs[11] = '{1'b1,1'b1,MODE_T, 4'b1111,4'b0000,1'b1,4'b1111,1'b0,4'b0000,4'b0000,4'd0};
        vecs[12] = '{1'b0,1'b1,MODE_D, 4'b0110,4'b1111,1'b0,4'b0000,1'b0,4'b0110,4'b0000,4'd2};
        vecs[13] = '{1'b0,1'b1,MODE_T, 4'b0011,4'b0000,1'b0,4'b0000,1'b0,4'b0101,4'b0000,4'd4};
        vecs[14] = '{1'b0,1'b0,MODE_JK,4'b0000,4'b0000,1'b0,4'b0000,1'b1,4'b0101,4'b0000,4'd4};
        vecs[15] = '{1'b0,1'b1,MODE_JK,4'b0011,4'b0101,1'b0,4'b0000,1'b0,4'b0010,4'b0000,4'd7};
        vecs[16] = '{1'b1,1'b0,MODE_JK,4'b0000,4'b0000,1'b0,4'b0000,1'b0,4'b0000,4'b0000,4'd0};
        vecs[17] = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b1111,4'b0000,4'd4};
        vecs[18] = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b0000,4'b0000,4'd8};
        vecs[19] = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b1111,4'b0000,4'd12};
        vecs[20] = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b0000,4'b0000,4'd15};
        vecs[21] = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,4'b1111,4'b0000,4'd15};

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        // Long toggle run: counter must stick at 15 rather than wrap.
        v = '{1'b1,1'b0,MODE_JK,4'b0000,4'b0000,1'b0,4'b0000,1'b0,4'b0000,4'b0000,4'd0};
        apply(v, 100);
        q_model = 4'b0000;
        cnt_model = 0;
        for (int n = 0; n < 12; n++) begin
            q_model = ~q_model;
            cnt_model = (cnt_model + 4 > 15) ? 15 : cnt_model + 4;
            v = '{1'b0,1'b1,MODE_JK,4'b1111,4'b1111,1'b0,4'b0000,1'b0,q_model,4'b0000,CW'(cnt_model)};
            apply(v, 101 + n);
        end
        // Reset with a load and an SR error in flight: reset wins everywhere.
        v = '{1'b1,1'b1,MODE_SR,4'b1111,4'b1111,1'b1,4'b1010,1'b0,4'b0000,4'b0000,4'd0};
        apply(v, 200);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_register_bank.md
Name: jk_register_bank

Overview:
Parametrised bank of WIDTH independent bistable channels sharing one clock. A runtime mode selects JK, SR, D or T next-state behaviour for all channels.
- Channel j/k inputs are interpreted according to the selected mode.
- qn is always driven as the true complement of q.
- Adds clock enable, parallel load, sticky per-channel SR-illegal flags and a saturating transition counter.
- Serves as the general-purpose state-register primitive for the mixed-signal control path, replacing single-bit flip-flop instances.

Parameters:
WIDTH, 8, number of channels.
RST_VAL, {WIDTH{1'b0}}, value of q after reset.
CNT_W, 16, width of the transition counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
en  in  1  clock enable for mode-driven updates.
mode  in  2  00=JK, 01=SR, 10=D, 11=T.
j  in  WIDTH  J / S / D / T input per channel.
k  in  WIDTH  K / R input per channel; ignored in D and T modes.
load  in  1  parallel load strobe.
load_data  in  WIDTH  value loaded into q.
clr_err  in  1  clears sticky sr_err flags.
q  out  WIDTH  channel state.
qn  out  WIDTH  always equal to ~q, registered alongside q.
sr_err  out  WIDTH  sticky flag: S=R=1 was applied in SR mode while enabled.
chg_cnt  out  CNT_W  saturating count of q bit transitions.

Behaviour:
- Reset: on a rising edge with rst=1, q=RST_VAL, qn=~RST_VAL, sr_err=0 and chg_cnt=0. Reset overrides every other input, including a load or update in flight.
- Priority per edge: rst > load > en > hold.
- load=1: q<=load_data in one cycle regardless of en or mode. sr_err is not updated by the load.
- en=1, load=0: each bit i is updated per mode.
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - SR: 00 hold, 01 clear, 10 set, 11 hold and set sr_err[i].
  - D: q[i]<=j[i].
  - T: j[i]=1 toggles, j[i]=0 holds.
- en=0, load=0: q holds; sr_err is not set.
- Latency: q, qn, sr_err and chg_cnt all reflect the inputs from the previous edge (one cycle). No combinational path from inputs to outputs.
- qn is updated on the same edge as q; q^qn equals all-ones at every cycle boundary.
- sr_err:
  - Sticky; clr_err=1 clears it on the next edge.
  - If clr_err and a new SR error on the same bit coincide, the new error wins (the bit is set).
  - clr_err has no effect on q.
- chg_cnt:
  - Each edge, add popcount(q_next ^ q) for non-reset updates, including loads.
  - Saturate at 2^CNT_W-1; never wrap.
  - Cleared only by rst.
- mode changes take effect on the same edge they are sampled. There is no pipeline, so a mid-stream mode change needs no special handling.
- The default/unknown mode branch holds q, giving a lint-clean case.

Decomposition:
- Package ff_pkg holds:
  - mode constants MODE_JK=2'b00, MODE_SR=2'b01, MODE_D=2'b10, MODE_T=2'b11;
  - a 2-bit mode typedef.
- One sub-module, jk_cell: combinational next-state and error-set for a single channel.
  - Inputs: mode, j, k, q.
  - Outputs: q_next, err_set.
  - Instantiated WIDTH times via a generate loop.
- The top level owns the registers, load/enable priority, popcount and the saturating counter.

Test Plan:
(All scenarios use WIDTH=4, CNT_W=4, RST_VAL=4'b0000.)
1. Reset/complement: rst=1 for 1 edge -> q=0000, qn=1111, sr_err=0000, chg_cnt=0. Then JK mode, en=1, j=1010, k=0101 -> q=1010, qn=0101, chg_cnt=2.
2. JK toggle: from q=1010, j=k=1111 for 2 edges -> q=0101 then 1010; chg_cnt increments by 4 each edge.
3. SR illegal: SR mode, en=1, j=0011, k=0110 -> q bit0 set, bit2 clear, bit1 held, sr_err=0010. Next cycle clr_err=1 with j=k=0000 -> sr_err=0000. Separately, clr_err=1 together with j=k=0010 -> sr_err stays 0010.
4. Priority: load=1, load_data=1100, en=1, T mode, j=1111 -> q=1100 (load wins). Then load=0, en=0 -> q holds 1100. Then rst=1 with load=1 -> q=0000.
5. D/T modes: D mode, j=0110, k=1111 -> q=0110. Then T mode, j=0011 -> q=0101.
6. Counter saturation: JK toggle all bits repeatedly with CNT_W=4 -> chg_cnt reads 4, 8, 12, then 15, and stays 15. rst -> 0.
